// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline <-> hazard control unit signal bundle
// Purpose: groups the pipeline observation inputs and the stall/flush controls
//          of the hazard control unit into one bundle.
// Modports:
//   master - pipeline side: drives register/load/memory/branch status,
//            receives stall/flush controls, state and counters
//   slave  - hazard control unit side (mirror of master)
interface hazard_control_unit_if;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
  logic        IF_ID_uses_rs1;
  logic        IF_ID_uses_rs2;
  logic [4:0]  ID_EX_rd;
  logic        ID_EX_mem_read;
  logic        EX_MEM_mem_req;
  logic        dmem_ready;
  logic        branch_taken;

  logic        pc_write_en;
  logic        IF_ID_write_en;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        pipe_hold;
  logic [1:0]  hz_state;
  logic [31:0] stall_count;
  logic [31:0] flush_count;
  logic        mem_timeout;

  modport master (
    output IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs1, IF_ID_uses_rs2,
           ID_EX_rd, ID_EX_mem_read, EX_MEM_mem_req, dmem_ready, branch_taken,
    input  pc_write_en, IF_ID_write_en, IF_ID_flush, ID_EX_flush, pipe_hold,
           hz_state, stall_count, flush_count, mem_timeout
  );

  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs1, IF_ID_uses_rs2,
           ID_EX_rd, ID_EX_mem_read, EX_MEM_mem_req, dmem_ready, branch_taken,
    output pc_write_en, IF_ID_write_en, IF_ID_flush, ID_EX_flush, pipe_hold,
           hz_state, stall_count, flush_count, mem_timeout
  );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard detection, stall/flush control and counters
// Purpose: decides each cycle whether the pipeline runs, freezes for data
//          memory, flushes on a taken branch, or inserts a load-use bubble.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - hazard_control_unit_if.slave: pipeline status in; PC/IF_ID/ID_EX
//          controls (combinational), hz_state, stall/flush counters and the
//          sticky mem_timeout flag (registered) out
module hazard_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  hazard_control_unit_if.slave bus
);

  localparam logic [7:0]  WAIT_MAX = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_MEM_WAIT   = 2'd2,
    HZ_FLUSH      = 2'd3
  } hz_state_t;

  logic      w_mem_wait;
  logic      w_rs1_hit;
  logic      w_rs2_hit;
  logic      w_load_use;
  hz_state_t w_action;

  logic      w_pc_write_en;
  logic      w_if_id_write_en;
  logic      w_if_id_flush;
  logic      w_id_ex_flush;
  logic      w_pipe_hold;

  hz_state_t   r_hz_state;
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_timeout;

  assign w_mem_wait = bus.EX_MEM_mem_req && !bus.dmem_ready;
  assign w_rs1_hit  = bus.IF_ID_uses_rs1 && (bus.IF_ID_rs1 == bus.ID_EX_rd);
  assign w_rs2_hit  = bus.IF_ID_uses_rs2 && (bus.IF_ID_rs2 == bus.ID_EX_rd);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign w_load_use = bus.ID_EX_mem_read && (bus.ID_EX_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

  // Winning action. A memory freeze masks everything because EX is frozen;
  // a taken branch masks load-use because the dependent instruction is squashed.
  always_comb begin
    w_action = HZ_RUN;
    if (w_mem_wait) begin
      w_action = HZ_MEM_WAIT;
    end else if (bus.branch_taken) begin
      w_action = HZ_FLUSH;
    end else if (w_load_use) begin
      w_action = HZ_LOAD_STALL;
    end
  end

  always_comb begin
    w_pc_write_en    = 1'b1;
    w_if_id_write_en = 1'b1;
    w_if_id_flush    = 1'b0;
    w_id_ex_flush    = 1'b0;
    w_pipe_hold      = 1'b0;
    if (!rst) begin
      case (w_action)
        HZ_MEM_WAIT: begin
          w_pc_write_en    = 1'b0;
          w_if_id_write_en = 1'b0;
          w_pipe_hold      = 1'b1;
        end
        HZ_FLUSH: begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end
        HZ_LOAD_STALL: begin
          w_pc_write_en    = 1'b0;
          w_if_id_write_en = 1'b0;
          w_id_ex_flush    = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hz_state    <= HZ_RUN;
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
      r_wait_cnt    <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_hz_state <= w_action;

      if ((w_action == HZ_MEM_WAIT || w_action == HZ_LOAD_STALL) && r_stall_count != CNT_MAX) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (w_action == HZ_FLUSH && r_flush_count != CNT_MAX) begin
        r_flush_count <= r_flush_count + 32'd1;
      end

      // Wait counter tracks consecutive freeze cycles; reaching the limit
      // raises the sticky flag but does not release the freeze.
      if (w_mem_wait) begin
        if (r_wait_cnt == WAIT_MAX) begin
          r_mem_timeout <= 1'b1;
        end else begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
        end
      end else begin
        r_wait_cnt <= 8'd0;
      end
    end
  end

  assign bus.pc_write_en    = w_pc_write_en;
  assign bus.IF_ID_write_en = w_if_id_write_en;
  assign bus.IF_ID_flush    = w_if_id_flush;
  assign bus.ID_EX_flush    = w_id_ex_flush;
  assign bus.pipe_hold      = w_pipe_hold;
  assign bus.hz_state       = r_hz_state;
  assign bus.stall_count    = r_stall_count;
  assign bus.flush_count    = r_flush_count;
  assign bus.mem_timeout    = r_mem_timeout;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_control_unit_if bus();

  hazard_control_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [1:0]  m_hz = 2'd0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
  int          m_consec = 0;
  logic        m_timeout = 1'b0;

  logic [4:0]  act_ctl;
  logic [66:0] act_regs;
  assign act_ctl  = {bus.pc_write_en, bus.IF_ID_write_en, bus.IF_ID_flush, bus.ID_EX_flush, bus.pipe_hold};
  assign act_regs = {bus.hz_state, bus.stall_count, bus.flush_count, bus.mem_timeout};

  function automatic logic [66:0] exp_regs();
    return {m_hz, m_stall, m_flush, m_timeout};
  endfunction

  // 0 run, 1 load stall, 2 memory wait, 3 flush
  function automatic int winner();
    bit lu;
    lu = bus.ID_EX_mem_read && bus.ID_EX_rd != 0 &&
         ((bus.IF_ID_uses_rs1 && bus.IF_ID_rs1 == bus.ID_EX_rd) ||
          (bus.IF_ID_uses_rs2 && bus.IF_ID_rs2 == bus.ID_EX_rd));
    if (bus.EX_MEM_mem_req && !bus.dmem_ready) return 2;
    if (bus.branch_taken) return 3;
    if (lu) return 1;
    return 0;
  endfunction

  // {pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_hold}
  function automatic logic [4:0] exp_ctl();
    if (rst) return 5'b11000;
    case (winner())
      2:       return 5'b00001;
      3:       return 5'b11110;
      1:       return 5'b00010;
      default: return 5'b11000;
    endcase
  endfunction

  task automatic model_edge();
    int w;
    if (rst) begin
      m_hz = 0; m_stall = 0; m_flush = 0; m_consec = 0; m_timeout = 0;
    end else begin
      w = winner();
      m_hz = 2'(w);
      if ((w == 1 || w == 2) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (w == 3 && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
      if (w == 2) begin
        m_consec = m_consec + 1;
        if (m_consec >= TO) m_timeout = 1'b1;
      end else begin
        m_consec = 0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1, input logic u2, input logic [4:0] d,
                       input logic mr, input logic mq, input logic rdy, input logic br);
    @(negedge clk);
    rst = r;
    bus.IF_ID_rs1 = s1; bus.IF_ID_rs2 = s2;
    bus.IF_ID_uses_rs1 = u1; bus.IF_ID_uses_rs2 = u2;
    bus.ID_EX_rd = d; bus.ID_EX_mem_read = mr;
    bus.EX_MEM_mem_req = mq; bus.dmem_ready = rdy; bus.branch_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, 1);
      n_cmp++;
      if (act_ctl !== 5'b11000) begin n_bad++; $display("FAIL reset_ctl: got %b expected %b", act_ctl, 5'b11000); end
      tick();
      n_cmp++;
      if (act_regs !== 67'd0) begin n_bad++; $display("FAIL reset_regs: got %h expected 0", act_regs); end
    end
  endtask

  task automatic test_load_use();
    drive(0, 5'd3, 5'd5, 1, 1, 5'd5, 1, 0, 1, 0);
    n_cmp++;
    if (act_ctl !== 5'b00010) begin n_bad++; $display("FAIL lu_ctl: got %b expected %b", act_ctl, 5'b00010); end
    tick();
    n_cmp++;
    if (bus.hz_state !== 2'd1 || bus.stall_count !== 32'd1)
      begin n_bad++; $display("FAIL lu_regs: got hz=%0d stall=%0d expected hz=1 stall=1", bus.hz_state, bus.stall_count); end
    drive(0, 5'd3, 5'd5, 1, 1, 5'd0, 0, 0, 1, 0);
    n_cmp++;
    if (act_ctl !== 5'b11000) begin n_bad++; $display("FAIL lu_bubble_ctl: got %b expected %b", act_ctl, 5'b11000); end
    tick();
    n_cmp++;
    if (bus.hz_state !== 2'd0 || bus.stall_count !== 32'd1)
      begin n_bad++; $display("FAIL lu_bubble_regs: got hz=%0d stall=%0d expected hz=0 stall=1", bus.hz_state, bus.stall_count); end
  endtask

  task automatic test_no_stall();
    drive(0, 5'd0, 5'd9, 1, 1, 5'd0, 1, 0, 1, 0);
    n_cmp++;
    if (act_ctl !== 5'b11000) begin n_bad++; $display("FAIL x0_ctl: got %b expected %b", act_ctl, 5'b11000); end
    tick();
    drive(0, 5'd7, 5'd2, 0, 1, 5'd7, 1, 0, 1, 0);
    n_cmp++;
    if (act_ctl !== 5'b11000) begin n_bad++; $display("FAIL unused_ctl: got %b expected %b", act_ctl, 5'b11000); end
    tick();
    n_cmp++;
    if (bus.stall_count !== 32'd1 || bus.hz_state !== 2'd0)
      begin n_bad++; $display("FAIL no_stall_regs: got stall=%0d hz=%0d expected stall=1 hz=0", bus.stall_count, bus.hz_state); end
  endtask

  task automatic test_mem_wait();
    int holds = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 5'd1, 5'd2, 1, 1, 5'd1, 1, 1, (i == 3), 1);
      n_cmp++;
      if (act_ctl !== exp_ctl()) begin n_bad++; $display("FAIL mw_ctl[%0d]: got %b expected %b", i, act_ctl, exp_ctl()); end
      if (bus.pipe_hold === 1'b1) holds++;
      tick();
    end
    n_cmp++;
    if (holds != 3 || bus.stall_count !== 32'd3 || bus.mem_timeout !== 1'b0)
      begin n_bad++; $display("FAIL mw_summary: got holds=%0d stall=%0d to=%b expected 3 3 0", holds, bus.stall_count, bus.mem_timeout); end
  endtask

  task automatic test_branch_load();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 5'd5, 5'd5, 1, 1, 5'd5, 1, 0, 1, 1);
    n_cmp++;
    if (act_ctl !== 5'b11110) begin n_bad++; $display("FAIL br_ctl: got %b expected %b", act_ctl, 5'b11110); end
    tick();
    n_cmp++;
    if (bus.flush_count !== 32'd1 || bus.stall_count !== 32'd0 || bus.hz_state !== 2'd3)
      begin n_bad++; $display("FAIL br_regs: got flush=%0d stall=%0d hz=%0d expected 1 0 3", bus.flush_count, bus.stall_count, bus.hz_state); end
  endtask

  task automatic test_timeout();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    for (int i = 0; i < TO; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      n_cmp++;
      if (act_ctl !== 5'b00001) begin n_bad++; $display("FAIL to_ctl[%0d]: got %b expected %b", i, act_ctl, 5'b00001); end
      tick();
      n_cmp++;
      if (bus.mem_timeout !== (i == TO - 1)) begin n_bad++; $display("FAIL to_flag[%0d]: got %b expected %b", i, bus.mem_timeout, (i == TO - 1)); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      tick();
    end
    n_cmp++;
    if (bus.mem_timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b expected 1", bus.mem_timeout); end
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    n_cmp++;
    if (bus.mem_timeout !== 1'b0) begin n_bad++; $display("FAIL to_reset: got %b expected 0", bus.mem_timeout); end
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    force dut.r_stall_count = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_count;
    m_stall = 32'hFFFF_FFFD;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick();
      n_cmp++;
      if (act_regs !== exp_regs()) begin n_bad++; $display("FAIL sat_regs[%0d]: got %h expected %h", i, act_regs, exp_regs()); end
    end
    n_cmp++;
    if (bus.stall_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_value: got %h expected ffffffff", bus.stall_count); end
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    n_cmp++;
    if (act_regs !== 67'd0) begin n_bad++; $display("FAIL mid_wait_reset: got %h expected 0", act_regs); end
    for (int i = 0; i < TO; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick();
    end
    n_cmp++;
    if (bus.mem_timeout !== 1'b1 || bus.stall_count !== 32'(TO))
      begin n_bad++; $display("FAIL post_reset_wait: got to=%b stall=%0d expected 1 %0d", bus.mem_timeout, bus.stall_count, TO); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 29) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
      n_cmp++;
      if (act_ctl !== exp_ctl()) begin n_bad++; $display("FAIL rnd_ctl[%0d]: got %b expected %b", i, act_ctl, exp_ctl()); end
      tick();
      n_cmp++;
      if (act_regs !== exp_regs()) begin n_bad++; $display("FAIL rnd_regs[%0d]: got %h expected %h", i, act_regs, exp_regs()); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.IF_ID_rs1 = 0; bus.IF_ID_rs2 = 0; bus.IF_ID_uses_rs1 = 0; bus.IF_ID_uses_rs2 = 0;
    bus.ID_EX_rd = 0; bus.ID_EX_mem_read = 0; bus.EX_MEM_mem_req = 0;
    bus.dmem_ready = 1; bus.branch_taken = 0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_mem_wait();
    test_branch_load();
    test_timeout();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum number of consecutive data-memory wait cycles before a timeout is flagged (range 2..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 IF_ID_rs1, IF_ID_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 IF_ID_uses_rs1, IF_ID_uses_rs2  input  1 each  ID instruction actually reads that source.
REQ-006 ID_EX_rd  input  5  destination of the instruction in EX.
REQ-007 ID_EX_mem_read  input  1  EX instruction is a load.
REQ-008 EX_MEM_mem_req  input  1  MEM instruction accesses data memory (load or store).
REQ-009 dmem_ready  input  1  data memory completes the access this cycle.
REQ-010 branch_taken  input  1  branch/jump resolved taken in EX this cycle; PC redirect.
REQ-011 pc_write_en  output  1  PC may update.
REQ-012 IF_ID_write_en  output  1  IF/ID register may load.
REQ-013 IF_ID_flush  output  1  IF/ID loads a NOP.
REQ-014 ID_EX_flush  output  1  ID/EX loads a bubble (all control zero).
REQ-015 pipe_hold  output  1  ID/EX, EX/MEM and MEM/WB registers hold their values.
REQ-016 hz_state  output  2  registered class of the previous cycle's action: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT, 3 FLUSH.
REQ-017 stall_count, flush_count  output  32 each  performance counters.
REQ-018 mem_timeout  output  1  sticky error flag.

Function
REQ-019 Control outputs (REQ-011..015) SHALL be combinational from the current inputs; hz_state, the counters, the wait counter and mem_timeout SHALL be registered.
REQ-020 Condition mem_wait = EX_MEM_mem_req && !dmem_ready.
REQ-021 Condition load_use = ID_EX_mem_read && ID_EX_rd != 0 && ((IF_ID_uses_rs1 && IF_ID_rs1 == ID_EX_rd) || (IF_ID_uses_rs2 && IF_ID_rs2 == ID_EX_rd)).
REQ-022 Priority SHALL be mem_wait > branch_taken > load_use > none.
REQ-023 mem_wait: pc_write_en=0, IF_ID_write_en=0, pipe_hold=1, both flushes=0; branch_taken and load_use are ignored because EX is frozen and both are re-evaluated when the freeze releases.
REQ-024 branch_taken (no mem_wait): pc_write_en=1, IF_ID_write_en=1, IF_ID_flush=1, ID_EX_flush=1, pipe_hold=0; a coincident load_use SHALL NOT stall, because the younger instruction is squashed.
REQ-025 load_use (no higher condition): pc_write_en=0, IF_ID_write_en=0, ID_EX_flush=1, IF_ID_flush=0, pipe_hold=0; this gives exactly one bubble, and the next cycle re-evaluates with the bubble in EX.
REQ-026 none: pc_write_en=1, IF_ID_write_en=1, all other controls 0.
REQ-027 hz_state SHALL load 2, 3, 1 or 0 per the winning condition each cycle.
REQ-028 stall_count SHALL increment by 1 in each cycle with mem_wait or load_use winning.
REQ-029 flush_count SHALL increment by 1 in each branch_taken cycle that wins.
REQ-030 Both counters SHALL saturate at 0xFFFFFFFF.
REQ-031 An 8-bit wait counter SHALL increment on each mem_wait cycle and clear on any cycle without mem_wait.
REQ-032 When mem_wait holds with wait counter == TIMEOUT_CYCLES-1, mem_timeout SHALL set on that edge; it remains set until rst; the freeze continues regardless.
REQ-033 The wait counter SHALL saturate at TIMEOUT_CYCLES-1.

Reset
REQ-034 While rst=1 at an edge: hz_state=0, stall_count=0, flush_count=0, wait counter=0, mem_timeout=0.
REQ-035 During reset cycles, control outputs SHALL be forced to the "none" values (REQ-026).
REQ-036 Reset asserted mid-MEM_WAIT or mid-count SHALL abort it with no residual state.

Verification
REQ-037 Load x5 in EX, ID instruction reads rs2=x5 -> one cycle: pc_write_en=0, ID_EX_flush=1; hz_state=1 next cycle; stall_count=1.
REQ-038 Load with ID_EX_rd=0 matching rs1=0, or match with uses_rs1=0 -> no stall; stall_count unchanged.
REQ-039 EX_MEM_mem_req=1, dmem_ready=0 for 3 cycles then 1 -> pipe_hold=1 for exactly 3 cycles; stall_count=3; mem_timeout=0.
REQ-040 branch_taken and load_use in the same cycle -> both flushes=1, pc_write_en=1; flush_count=1, stall_count=0.
REQ-041 mem_wait held for TIMEOUT_CYCLES=16 cycles -> mem_timeout=1 after the 16th edge and stays 1 after dmem_ready; cleared only by rst.
REQ-042 Preload stall_count near 0xFFFFFFFF via long mem_wait (or forced) -> stays 0xFFFFFFFF; rst mid-wait -> all registers 0 next cycle.
